shift_sched: RTL and testbench
==============================

Name: shift_sched

Overview:
Pipelined 64-bit log barrel shifter with an arbiter in front, shared by NREQ requesters.
- Six shift stages: stage k shifts by 2^k when shamt bit k is set, with a register after every stage.
- A round-robin arbiter admits at most one request per cycle.
- Results leave through a single valid/ready response port tagged with the requester index.
- Sits between the ALU issue logic and writeback as the sole owner of the shifter datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of the requester tag; must satisfy 2^IDW >= NREQ

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NREQ  requester i has a request
req_ready  out  NREQ  request i accepted this cycle
req_data  in  NREQ*64  operand, requester i at [64i+63:64i]
req_shamt  in  NREQ*6  shift amount, requester i at [6i+5:6i]
req_op  in  NREQ*2  requester i op: 00 SLL, 01 SRL, 10 SRA, 11 ROR
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  64  shifted result
rsp_id  out  IDW  index of the originating requester
busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Pipeline registers s0..s5. Each holds: valid, data, op, shamt, sign bit (bit 63 of the original operand), id.
  - s0 captures the granted request shifted by 2^0 if shamt[0] is set.
  - sk = s(k-1) shifted by 2^k if shamt[k] is set.
  - s5 drives rsp_valid, rsp_data and rsp_id directly from registers.
- Fill rules per op:
  - SLL and SRL: zero fill.
  - SRA: fill with the carried sign bit.
  - ROR: rotate right.
  - shamt 0: result equals operand, for every op.
- advance = !s5.valid || rsp_ready.
  - When advance=1, all stages shift forward and s0 loads the granted request, or a bubble if there is none.
  - When advance=0, every stage holds its value and all req_ready bits are 0.
- Bubbles are not collapsed. The pipeline is a fixed 6-deep shift register.
- Latency: a request accepted in cycle n has rsp_valid=1 in cycle n+6 when no stall occurs.
- Throughput: 1 result/cycle with rsp_ready held high.
- A response is consumed when rsp_valid && rsp_ready at the clock edge.
- rsp_valid, rsp_data and rsp_id remain stable while rsp_valid=1 and rsp_ready=0.
- Arbitration (round-robin):
  - Pointer ptr, range 0..NREQ-1.
  - Winner = first i with req_valid[i], scanning ptr, ptr+1, ... with wrap-around modulo NREQ.
  - req_ready[winner] = advance. All other req_ready bits = 0.
  - On an accepted handshake, ptr <= winner+1 mod NREQ.
  - With no handshake, ptr holds.
- req_ready may depend combinationally on req_valid and rsp_ready.
- A requester that drops req_valid before it is granted loses nothing; no state is kept for it.
- busy = OR of s0..s5 valid.
- Reset (rst_n=0 at a clock edge):
  - All stage valid bits clear, ptr=0, stage data, op, shamt and id registers are cleared to 0.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. req_ready=0 while rst_n=0.
  - In-flight entries are discarded with no response.
  - The first request can be accepted in the first cycle with rst_n=1.
- Simultaneous events:
  - A response consumed and a new request admitted in the same cycle are both legal.
  - All requesters valid every cycle: each requester receives exactly one grant per NREQ accepted handshakes.
- Synthesizable. No latches. Only the declared ports are visible.

Test Plan:
1. Single SRA: requester 1 sends data=0x8000_0000_0000_0000, shamt=4, op=10 in cycle 0, rsp_ready=1 -> rsp_valid in cycle 6, rsp_data=0xF800_0000_0000_0000, rsp_id=1. busy=1 during cycles 1..6.
2. Boundary ops, back-to-back from requester 0:
   - SLL 0xFFFF_FFFF_FFFF_FFFF by 63 -> 0x8000_0000_0000_0000
   - SRL 0x8000_0000_0000_0000 by 63 -> 0x1
   - ROR 0x1 by 1 -> 0x8000_0000_0000_0000
   - SRA 0x7FFF_FFFF_FFFF_FFFF by 63 -> 0x0
   - any op with shamt 0 -> unchanged operand
   - Required: results in consecutive cycles 6..10.
3. Fairness: all 4 requesters hold req_valid for 8 accepted handshakes, ptr=0 after reset -> grant order 0,1,2,3,0,1,2,3. rsp_id follows the same order.
4. Backpressure:
   - Stimulus: stream 10 requests; hold rsp_ready=0 for 5 cycles once rsp_valid rises.
   - Required: rsp_data and rsp_id stable; req_ready all 0 during the stall; no result lost or duplicated; all 10 results arrive in order.
5. Reset mid-operation:
   - Stimulus: 3 requests in flight; drive rst_n=0 for 1 cycle.
   - Required: rsp_valid=0, busy=0 and ptr=0 the next cycle; no stale response ever appears.
   - Then a new request completes with the normal 6-cycle latency.
6. Valid drop: requester 2 asserts req_valid for one cycle while requester 0 wins, then deasserts -> requester 2 is never granted and no response carries rsp_id=2.

Source files
------------

// File: rtl/shift_sched.sv
// Six-stage pipelined 64-bit log barrel shifter (SLL/SRL/SRA/ROR)
// fronted by a round-robin arbiter over NREQ requesters.
module shift_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*64-1:0]   req_data,
    input  logic [NREQ*6-1:0]    req_shamt,
    input  logic [NREQ*2-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);
    localparam int NST = 6;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [NST-1:0] vld;
    logic [63:0]    dat [NST];
    logic [1:0]     opr [NST];
    logic [5:0]     sha [NST];
    logic           sgn [NST];
    logic [IDW-1:0] tag [NST];
    logic [IDW-1:0] ptr;

    logic           advance;
    logic           any;
    logic [IDW-1:0] win;
    logic [63:0]    in_data;
    logic [5:0]     in_sh;
    logic [1:0]     in_op;

    // SRA fills with the original operand's sign, carried down the pipe
    function automatic logic [63:0] stage_shift(
        input logic [63:0] d,
        input logic [1:0]  op,
        input logic        sign,
        input int          amt
    );
        logic [63:0] ones;
        logic [63:0] res;
        ones = '1;
        case (op)
            OP_SLL:  res = d << amt;
            OP_SRL:  res = d >> amt;
            OP_SRA:  res = (d >> amt) | (sign ? ~(ones >> amt) : 64'd0);
            default: res = (d >> amt) | (d << (64 - amt));
        endcase
        return res;
    endfunction

    assign advance = !vld[NST-1] || rsp_ready;

    always_comb begin
        int idx;
        idx = 0;
        any = 1'b0;
        win = '0;
        for (int o = 0; o < NREQ; o++) begin
            idx = (int'(ptr) + o) % NREQ;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && any && advance)
            req_ready[win] = 1'b1;
    end

    assign in_data = any ? req_data[64*int'(win) +: 64] : 64'd0;
    assign in_sh   = any ? req_shamt[6*int'(win) +: 6] : 6'd0;
    assign in_op   = any ? req_op[2*int'(win) +: 2] : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            ptr <= '0;
            for (int k = 0; k < NST; k++) begin
                dat[k] <= '0;
                opr[k] <= '0;
                sha[k] <= '0;
                sgn[k] <= 1'b0;
                tag[k] <= '0;
            end
        end else if (advance) begin
            vld[0] <= any;
            dat[0] <= in_sh[0] ? stage_shift(in_data, in_op, in_data[63], 1)
                               : in_data;
            opr[0] <= in_op;
            sha[0] <= in_sh;
            sgn[0] <= in_data[63];
            tag[0] <= win;
            for (int k = 1; k < NST; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= sha[k-1][k]
                        ? stage_shift(dat[k-1], opr[k-1], sgn[k-1], 1 << k)
                        : dat[k-1];
                opr[k] <= opr[k-1];
                sha[k] <= sha[k-1];
                sgn[k] <= sgn[k-1];
                tag[k] <= tag[k-1];
            end
            if (any)
                ptr <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
        end
    end

    assign rsp_valid = vld[NST-1];
    assign rsp_data  = dat[NST-1];
    assign rsp_id    = tag[NST-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed scenarios plus a
// randomized run scored against a behavioural shift/arbiter model.
module tb_shift_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*64-1:0] req_data = '0;
    logic [NREQ*6-1:0] req_shamt = '0;
    logic [NREQ*2-1:0] req_op = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [63:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          id;
        logic [63:0] data;
    } ent_t;

    ent_t acc_q[$];
    ent_t rsp_q[$];

    shift_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .req_shamt(req_shamt),
        .req_op(req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_shift(
        input logic [63:0] d, input int s, input logic [1:0] op);
        logic signed [63:0] sd;
        sd = d;
        case (op)
            2'd0: return d << s;
            2'd1: return d >> s;
            2'd2: return sd >>> s;
            default: return (s == 0) ? d : ((d >> s) | (d << (64 - s)));
        endcase
    endfunction

    // Log every handshake just before the edge that completes it
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ent_t e;
                    e.cyc = cyc;
                    e.id = i;
                    e.data = ref_shift(req_data[64*i +: 64],
                                       int'(req_shamt[6*i +: 6]),
                                       req_op[2*i +: 2]);
                    acc_q.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                ent_t r;
                r.cyc = cyc;
                r.id = int'(rsp_id);
                r.data = rsp_data;
                rsp_q.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] d,
                           input int s, input logic [1:0] op);
        req_data[64*i +: 64] = d;
        req_shamt[6*i +: 6] = 6'(s);
        req_op[2*i +: 2] = op;
    endtask

    task automatic rand_all();
        for (int i = 0; i < NREQ; i++) begin
            int s;
            s = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) s = 0;
            if ($urandom_range(0, 7) == 0) s = 63;
            set_req(i, {$urandom, $urandom}, s, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic drain(input int n);
        for (int b = 0; b < 200 && rsp_q.size() < n; b++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        acc_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_reset();
        req_valid = '1;
        rand_all();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 ||
            rsp_id !== 2'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got=%b/%h/%0d/%b exp=0/0/0/0",
                     rsp_valid, rsp_data, rsp_id, busy);
        end
        req_valid = '0;
        rst_n = 1'b1;
        acc_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_single_sra();
        set_req(1, 64'h8000_0000_0000_0000, 4, 2'b10);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL sra_ready got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (busy !== (k <= 6) || rsp_valid !== (k == 6)) begin
                fails++;
                $display("FAIL sra_timing k=%0d got=%b/%b exp=%b/%b",
                         k, busy, rsp_valid, k <= 6, k == 6);
            end
            if (k == 6) begin
                checks++;
                if (rsp_data !== 64'hF800_0000_0000_0000 || rsp_id !== 2'd1) begin
                    fails++;
                    $display("FAIL sra_result got=%h/%0d exp=f800000000000000/1",
                             rsp_data, rsp_id);
                end
            end
            tick();
        end
        checks++;
        if (rsp_q.size() != 1 || acc_q.size() != 1) begin
            fails++;
            $display("FAIL sra_count got=%0d exp=1", rsp_q.size());
        end
    endtask

    task automatic test_boundary();
        logic [63:0] bd [8];
        logic [63:0] be [8];
        int          bs [8];
        logic [1:0]  bo [8];
        logic [63:0] r;
        acc_q.delete();
        rsp_q.delete();
        r = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
        bd[0] = 64'hFFFF_FFFF_FFFF_FFFF; bs[0] = 63; bo[0] = 2'b00;
        be[0] = 64'h8000_0000_0000_0000;
        bd[1] = 64'h8000_0000_0000_0000; bs[1] = 63; bo[1] = 2'b01;
        be[1] = 64'h1;
        bd[2] = 64'h1; bs[2] = 1; bo[2] = 2'b11;
        be[2] = 64'h8000_0000_0000_0000;
        bd[3] = 64'h7FFF_FFFF_FFFF_FFFF; bs[3] = 63; bo[3] = 2'b10;
        be[3] = 64'h0;
        for (int i = 4; i < 8; i++) begin
            bd[i] = r; bs[i] = 0; bo[i] = 2'(i - 4); be[i] = r;
        end
        for (int i = 0; i < 8; i++) begin
            set_req(0, bd[i], bs[i], bo[i]);
            req_valid = 4'b0001;
            tick();
        end
        req_valid = '0;
        drain(8);
        checks++;
        if (rsp_q.size() != 8 || acc_q.size() != 8) begin
            fails++;
            $display("FAIL bnd_count got=%0d exp=8", rsp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rsp_q[i].data !== be[i] || rsp_q[i].id != 0 ||
                    rsp_q[i].cyc != acc_q[0].cyc + 6 + i) begin
                    fails++;
                    $display("FAIL bnd_%0d got=%h id%0d c%0d exp=%h id0 c%0d",
                             i, rsp_q[i].data, rsp_q[i].id, rsp_q[i].cyc,
                             be[i], acc_q[0].cyc + 6 + i);
                end
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int b = 0; b < 100 && acc_q.size() < 8; b++) begin
            rand_all();
            req_valid = '1;
            tick();
        end
        req_valid = '0;
        drain(8);
        checks++;
        if (acc_q.size() != 8 || rsp_q.size() != 8) begin
            fails++;
            $display("FAIL fair_count got=%0d/%0d exp=8/8",
                     acc_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc_q[i].id != i % 4 || rsp_q[i].id != i % 4 ||
                    rsp_q[i].data !== acc_q[i].data) begin
                    fails++;
                    $display("FAIL fair_%0d got=%0d/%0d/%h exp=%0d/%0d/%h",
                             i, acc_q[i].id, rsp_q[i].id, rsp_q[i].data,
                             i % 4, i % 4, acc_q[i].data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          stall;
        bit          done;
        logic [63:0] hd;
        logic [IDW-1:0] hid;
        stall = 0;
        done = 0;
        hd = '0;
        hid = '0;
        acc_q.delete();
        rsp_q.delete();
        for (int b = 0; b < 300 && rsp_q.size() < 10; b++) begin
            if (acc_q.size() < 10) begin
                rand_all();
                req_valid = 4'($urandom_range(1, 15));
            end else begin
                req_valid = '0;
            end
            if (!done && rsp_valid) begin
                done = 1;
                stall = 5;
                hd = rsp_data;
                hid = rsp_id;
            end
            if (stall > 0) begin
                rsp_ready = 1'b0;
                #1;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== hd ||
                    rsp_id !== hid || req_ready !== 4'b0000) begin
                    fails++;
                    $display("FAIL bp_stall got=%b/%h/%0d/%b exp=1/%h/%0d/0000",
                             rsp_valid, rsp_data, rsp_id, req_ready, hd, hid);
                end
                stall--;
            end else begin
                rsp_ready = 1'b1;
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (acc_q.size() != 10 || rsp_q.size() != 10 || !done) begin
            fails++;
            $display("FAIL bp_count got=%0d/%0d exp=10/10",
                     acc_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rsp_q[i].data !== acc_q[i].data ||
                    rsp_q[i].id != acc_q[i].id) begin
                    fails++;
                    $display("FAIL bp_%0d got=%h/%0d exp=%h/%0d", i,
                             rsp_q[i].data, rsp_q[i].id,
                             acc_q[i].data, acc_q[i].id);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        acc_q.delete();
        rsp_q.delete();
        for (int i = 0; i < 3; i++) begin
            set_req(1, {$urandom, $urandom}, $urandom_range(0, 63),
                    2'($urandom_range(0, 3)));
            req_valid = 4'b0010;
            tick();
        end
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_q.size() != 0) begin
            fails++;
            $display("FAIL rmid_flush got=%b/%b/%0d exp=0/0/0",
                     rsp_valid, busy, rsp_q.size());
        end
        acc_q.delete();
        rand_all();
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rmid_ptr got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        drain(1);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (acc_q.size() != 1 || rsp_q.size() != 1) begin
            fails++;
            $display("FAIL rmid_count got=%0d/%0d exp=1/1",
                     acc_q.size(), rsp_q.size());
        end else begin
            checks++;
            if (rsp_q[0].id != 0 || rsp_q[0].data !== acc_q[0].data ||
                rsp_q[0].cyc != acc_q[0].cyc + 6) begin
                fails++;
                $display("FAIL rmid_rsp got=%0d/%h/lat%0d exp=0/%h/lat6",
                         rsp_q[0].id, rsp_q[0].data,
                         rsp_q[0].cyc - acc_q[0].cyc, acc_q[0].data);
            end
        end
    endtask

    task automatic test_valid_drop();
        do_reset();
        rand_all();
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL drop_ready got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        drain(2);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (acc_q.size() != 2 || rsp_q.size() != 2) begin
            fails++;
            $display("FAIL drop_count got=%0d/%0d exp=2/2",
                     acc_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rsp_q[i].id != 0 || rsp_q[i].data !== acc_q[i].data) begin
                    fails++;
                    $display("FAIL drop_%0d got=%0d/%h exp=0/%h", i,
                             rsp_q[i].id, rsp_q[i].data, acc_q[i].data);
                end
            end
        end
    endtask

    task automatic test_random();
        int          mp;
        bit          stl;
        logic [63:0] pd;
        logic [IDW-1:0] pid;
        do_reset();
        mp = 0;
        stl = 0;
        pd = '0;
        pid = '0;
        for (int c = 0; c < 400; c++) begin
            logic [NREQ-1:0] exp_rdy;
            bit adv;
            if (stl) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== pd || rsp_id !== pid) begin
                    fails++;
                    $display("FAIL rnd_hold c%0d got=%b/%h/%0d exp=1/%h/%0d",
                             c, rsp_valid, rsp_data, rsp_id, pd, pid);
                end
            end
            rand_all();
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            adv = !rsp_valid || rsp_ready;
            exp_rdy = '0;
            if (adv) begin
                for (int o = 0; o < NREQ; o++) begin
                    int idx;
                    idx = (mp + o) % NREQ;
                    if (exp_rdy == '0 && req_valid[idx]) exp_rdy[idx] = 1'b1;
                end
                for (int i = 0; i < NREQ; i++)
                    if (exp_rdy[i]) mp = (i + 1) % NREQ;
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rnd_grant c%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            stl = rsp_valid && !rsp_ready;
            pd = rsp_data;
            pid = rsp_id;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain(acc_q.size());
        checks++;
        if (rsp_q.size() != acc_q.size()) begin
            fails++;
            $display("FAIL rnd_count got=%0d exp=%0d", rsp_q.size(), acc_q.size());
        end else begin
            for (int i = 0; i < acc_q.size(); i++) begin
                checks++;
                if (rsp_q[i].data !== acc_q[i].data || rsp_q[i].id != acc_q[i].id) begin
                    fails++;
                    $display("FAIL rnd_%0d got=%h/%0d exp=%h/%0d", i,
                             rsp_q[i].data, rsp_q[i].id,
                             acc_q[i].data, acc_q[i].id);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_single_sra();
        test_boundary();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_valid_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
